// File: rtl/bus_ram_slave.sv
// bus_ram_slave: word-addressed RAM slave with programmable wait states and error pulse.
// Optional byte-strobe writes enabled by defining BUS_RAM_SLAVE_STRB_EN.
`default_nettype none

module bus_ram_slave #(
  parameter int unsigned               WIDTH       = 32,
  parameter int unsigned               ADDR_WIDTH  = 32,
  parameter int unsigned               DEPTH       = 1024,
  parameter int unsigned               WAIT_CYCLES = 1,
  parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  w_en_i,
`ifdef BUS_RAM_SLAVE_STRB_EN
  input  logic [WIDTH/8-1:0]    strb_i,
`endif
  output logic [WIDTH-1:0]      data_o,
  output logic                  ready_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned NBYTE = WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    load;
  logic                    to_resp;

  logic [ADDR_WIDTH-1:0]   offset;
  logic                    req_err;
  logic [IDX_W-1:0]        req_idx;
  logic [IDX_W-1:0]        rd_idx;

  logic [IDX_W-1:0]        idx_q;
  logic [WIDTH-1:0]        data_q;
  logic                    we_q;
  logic                    err_q;
  logic [NBYTE-1:0]        wr_strb;
  logic [WIDTH-1:0]        rdata;

  logic [WIDTH-1:0]        mem [DEPTH];

  // BASE_ADDR is DEPTH*4 aligned, so offset[1:0] equals the byte-lane bits of
  // addr_i and any set bit above the index field means out of range.
  assign offset  = addr_i - BASE_ADDR;
  assign req_err = (offset[1:0] != 2'b00) | (offset[ADDR_WIDTH-1:IDX_W+2] != '0);
  assign req_idx = offset[IDX_W+1:2];

  // With zero wait states the read happens on the accept edge, before idx_q is loaded.
  assign rd_idx  = (state == S_IDLE) ? req_idx : idx_q;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    to_resp    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (valid_i) begin
          load = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            to_resp    = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!valid_i) begin
          state_next = S_IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_next = S_RESP;
            to_resp    = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (load) begin
      idx_q  <= req_idx;
      data_q <= data_i;
      we_q   <= w_en_i;
      err_q  <= req_err;
    end
  end

`ifdef BUS_RAM_SLAVE_STRB_EN
  logic [NBYTE-1:0] strb_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      strb_q <= '0;
    end else if (load) begin
      strb_q <= strb_i;
    end
  end

  assign wr_strb = strb_q;
`else
  assign wr_strb = '1;
`endif

  // RAM array carries no reset so it maps onto block memory.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (state == S_RESP) && we_q && !err_q) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (wr_strb[b]) begin
          mem[idx_q][8*b +: 8] <= data_q[8*b +: 8];
        end
      end
    end
    if (to_resp) begin
      rdata <= mem[rd_idx];
    end
  end

  assign ready_o = (state == S_RESP);
  assign err_o   = ready_o & err_q;
  assign data_o  = (ready_o && !err_q) ? rdata : '0;
  assign busy_o  = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bus_ram_slave.sv
// Directed self-checking bench for bus_ram_slave (one instance with one wait state, one with none).
`default_nettype none

module tb_bus_ram_slave;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        valid [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        we    [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];
`ifdef BUS_RAM_SLAVE_STRB_EN
  logic [3:0]  strb  [2];
`endif

  int checks   = 0;
  int failures = 0;

  bus_ram_slave #(.WAIT_CYCLES(1)) dut1 (
    .clk_i   (clk),
    .rst_ni  (rst_n[1]),
    .valid_i (valid[1]),
    .addr_i  (addr[1]),
    .data_i  (wdata[1]),
    .w_en_i  (we[1]),
`ifdef BUS_RAM_SLAVE_STRB_EN
    .strb_i  (strb[1]),
`endif
    .data_o  (rdata[1]),
    .ready_o (ready[1]),
    .err_o   (err[1]),
    .busy_o  (busy[1])
  );

  bus_ram_slave #(.WAIT_CYCLES(0)) dut0 (
    .clk_i   (clk),
    .rst_ni  (rst_n[0]),
    .valid_i (valid[0]),
    .addr_i  (addr[0]),
    .data_i  (wdata[0]),
    .w_en_i  (we[0]),
`ifdef BUS_RAM_SLAVE_STRB_EN
    .strb_i  (strb[0]),
`endif
    .data_o  (rdata[0]),
    .ready_o (ready[0]),
    .err_o   (err[0]),
    .busy_o  (busy[0])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge. Latency counts rising edges
  // from driving the request to the negedge where ready is first seen.
  task automatic req(input int s, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] st, input bit keep,
                     output int lat, output logic [31:0] rd, output logic e);
    valid[s] = 1'b1;
    we[s]    = w;
    addr[s]  = a;
    wdata[s] = d;
`ifdef BUS_RAM_SLAVE_STRB_EN
    strb[s]  = st;
`else
    if (st == 4'hx) lat = 0;
`endif
    lat = -1;
    rd  = 'x;
    e   = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready[s]) begin
        lat = i;
        rd  = rdata[s];
        e   = err[s];
        break;
      end
    end
    if (!keep) begin
      valid[s] = 1'b0;
      @(negedge clk);
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        e;

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; valid[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
`ifdef BUS_RAM_SLAVE_STRB_EN
      strb[s] = 4'hF;
`endif
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Reset holds IDLE even with a pending write
    req(1, 1'b1, 32'h30, 32'h0A0A_0A0A, 4'hF, 1'b0, lat, rd, e);
    chk("w30_lat", 32'(lat), 32'd2);
    rst_n[1] = 1'b0;
    valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, ready[1]}, 32'd0);
      chk("rst_data",  rdata[1], 32'd0);
      chk("rst_busy",  {31'd0, busy[1]}, 32'd0);
    end
    rst_n[1] = 1'b1;
    valid[1] = 1'b0;
    @(negedge clk);
    req(1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("r30_after_rst", rd, 32'h0A0A_0A0A);

    // Basic write/read with one wait state
    req(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, rd, e);
    chk("w10_lat", 32'(lat), 32'd2);
    chk("w10_err", {31'd0, e}, 32'd0);
    req(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("r10_lat",  32'(lat), 32'd2);
    chk("r10_data", rd, 32'hDEAD_BEEF);
    chk("r10_err",  {31'd0, e}, 32'd0);
    req(1, 1'b1, 32'h0, 32'hCAFE_0000, 4'hF, 1'b0, lat, rd, e);

    // Rejected accesses
    req(1, 1'b1, 32'h12, 32'h1234_5678, 4'hF, 1'b0, lat, rd, e);
    chk("mis_lat",  32'(lat), 32'd2);
    chk("mis_err",  {31'd0, e}, 32'd1);
    chk("mis_data", rd, 32'd0);
    req(1, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 1'b0, lat, rd, e);
    chk("oor_w_err",  {31'd0, e}, 32'd1);
    chk("oor_w_data", rd, 32'd0);
    req(1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("oor_r_err",  {31'd0, e}, 32'd1);
    chk("oor_r_data", rd, 32'd0);
    req(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("r10_unchanged", rd, 32'hDEAD_BEEF);
    req(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("r0_unchanged", rd, 32'hCAFE_0000);

    // Last word in range
    req(1, 1'b1, 32'hFFC, 32'h5A5A_A5A5, 4'hF, 1'b0, lat, rd, e);
    chk("wffc_err", {31'd0, e}, 32'd0);
    req(1, 1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("rffc_data", rd, 32'h5A5A_A5A5);
    chk("rffc_err",  {31'd0, e}, 32'd0);

    // Reset during WAIT aborts the write
    req(1, 1'b1, 32'h20, 32'h2020_2020, 4'hF, 1'b0, lat, rd, e);
    valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h9999_9999;
    @(negedge clk);
    chk("wait_busy", {31'd0, busy[1]}, 32'd1);
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("abort_rst_busy",  {31'd0, busy[1]}, 32'd0);
    chk("abort_rst_ready", {31'd0, ready[1]}, 32'd0);
    rst_n[1] = 1'b1;
    valid[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, ready[1]}, 32'd0);
    req(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("r20_after_rst", rd, 32'h2020_2020);

    // valid_i dropped during WAIT aborts the write
    valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h7777_7777;
    @(negedge clk);
    chk("wait_busy2", {31'd0, busy[1]}, 32'd1);
    valid[1] = 1'b0;
    @(negedge clk);
    chk("abort_v_busy",  {31'd0, busy[1]}, 32'd0);
    chk("abort_v_ready", {31'd0, ready[1]}, 32'd0);
    @(negedge clk);
    chk("abort_v_ready2", {31'd0, ready[1]}, 32'd0);
    req(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("r20_after_drop", rd, 32'h2020_2020);

    // Zero wait states, back-to-back reads
    req(0, 1'b1, 32'h0, 32'h0000_1000, 4'hF, 1'b0, lat, rd, e);
    chk("z_w0_lat", 32'(lat), 32'd1);
    req(0, 1'b1, 32'h4, 32'h0000_2004, 4'hF, 1'b0, lat, rd, e);
    req(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, lat, rd, e);
    chk("z_r0_lat",  32'(lat), 32'd1);
    chk("z_r0_data", rd, 32'h0000_1000);
    req(0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("z_r4_lat",  32'(lat), 32'd2);
    chk("z_r4_data", rd, 32'h0000_2004);
    chk("z_r4_err",  {31'd0, e}, 32'd0);

`ifdef BUS_RAM_SLAVE_STRB_EN
    req(1, 1'b1, 32'h0, 32'h1111_1111, 4'hF, 1'b0, lat, rd, e);
    req(1, 1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, 1'b0, lat, rd, e);
    req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, lat, rd, e);
    chk("strb_data", rd, 32'h11BB_11DD);
    req(1, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0000, 1'b0, lat, rd, e);
    chk("strb0_lat", 32'(lat), 32'd2);
    chk("strb0_err", {31'd0, e}, 32'd0);
    req(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, lat, rd, e);
    chk("strb0_data", rd, 32'h11BB_11DD);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
